div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: DW, 32, operand/result width; only 32 is supported.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  EX stage presents a divide op.
REQ-005 req_ready  out  1  controller accepts the op this cycle.
REQ-006 div_op  in  4  one-hot {mod.wu, mod.w, div.wu, div.w}, bits [3:0].
REQ-007 src1 / src2  in  32 each  dividend / divisor.
REQ-008 flush  in  1  ex_flush|ertn_flush; kills the in-flight op.
REQ-009 sdvd_tvalid, sdvr_tvalid  out  1 each  signed-IP dividend/divisor channel valid.
REQ-010 sdvd_tready, sdvr_tready  in  1 each  signed-IP channel ready.
REQ-011 sdvd_tdata, sdvr_tdata  out  32 each  signed-IP operands.
REQ-012 udvd_*, udvr_*  same set as REQ-009..011, for the unsigned IP.
REQ-013 sdout_tvalid / udout_tvalid  in  1 each  IP result valid; no back-pressure.
REQ-014 sdout_tdata / udout_tdata  in  64 each  {quotient[63:32], remainder[31:0]}.
REQ-015 res_valid  out  1  result held for the MEM side.
REQ-016 res_ready  in  1  MEM side consumes the result.
REQ-017 res_data  out  32  selected quotient or remainder.
REQ-018 busy  out  1  state != IDLE.

Function
REQ-019 FSM states: IDLE, SEND, WAIT, DONE, DRAIN.
REQ-020 req_ready = (state==IDLE) & ~flush.
REQ-021 Accept: req_valid & req_ready; latch src1, src2, div_op; clear the sent flags; go to SEND.
REQ-022 Signed IP is used iff div_op[0]|div_op[2]; otherwise the unsigned IP; the unused IP sees tvalid=0.
REQ-023 SEND: each channel tvalid = ~sent_flag for that channel.
REQ-024 A channel's flag sets on its tvalid&tready; the two channels complete independently, in any cycle order.
REQ-025 When both flags are set (including the same cycle as the last handshake), go to WAIT.
REQ-026 Flush in SEND with neither flag set: go to IDLE.
REQ-027 Flush in SEND with either flag set: stay in SEND until both channels are sent, then go to DRAIN; the IP must never see a half-op.
REQ-028 WAIT: on the selected dout_tvalid, capture res_data (quotient for div_op[1:0], remainder for div_op[3:2]) and go to DONE.
REQ-029 Flush in WAIT: go to DRAIN.
REQ-030 DRAIN: discard the next selected dout_tvalid, then go to IDLE; res_valid stays 0.
REQ-031 DONE: res_valid=1 and res_data is stable until res_valid&res_ready, then go to IDLE.
REQ-032 Flush in DONE: go to IDLE, res_valid=0 next cycle.
REQ-033 Flush in IDLE: no state change; a coincident req_valid is not accepted.
REQ-034 Minimum latency: accept -> res_valid = 2 cycles + IP latency; a new op is accepted the cycle after the DONE handshake.
REQ-035 Divide by zero and overflow: pass the IP output unchanged; no exception is raised.

Reset
REQ-036 resetn low clears immediately, mid-op included: state=IDLE, sent flags=0, all tvalid=0, res_valid=0, res_data=0, latched operands/op=0.
REQ-037 A result arriving after reset releases and before any accept is ignored.

Structure
REQ-038 A shared package holds the FSM state encoding and the div_op one-hot bit indices, which EX also uses.
REQ-039 One sub-module, div_chan_send: the per-channel tvalid/sent-flag handshake, instantiated twice (dividend, divisor).

Verification
REQ-040 div.w, src1=0xFFFFFFF9 (-7), src2=2, IP latency 8 -> res_data=0xFFFFFFFD, res_valid at accept+10.
REQ-041 mod.wu 7,3 -> udvd/udvr used, sdvd/sdvr tvalid never 1, res_data=1.
REQ-042 Divisor tready in the accept+1 cycle, dividend tready 3 cycles later -> each tvalid drops after its own handshake, WAIT entered once both are sent.
REQ-043 Flush in WAIT, then req_valid held -> req_ready=0 until the IP result is drained, then the next op completes correctly.
REQ-044 res_ready low 2 cycles in DONE -> res_data stable, single consume, IDLE after.
REQ-045 resetn asserted in SEND with one channel sent -> all outputs 0 asynchronously; the next op after release is correct.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide controller and the EX stage that feeds it:
// FSM state encoding and the one-hot div_op bit positions.
package div_ctrl_pkg;

  localparam int DIV_OP_W  = 4;

  localparam int OP_DIV_W  = 0;
  localparam int OP_DIV_WU = 1;
  localparam int OP_MOD_W  = 2;
  localparam int OP_MOD_WU = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } div_state_e;

  function automatic logic op_is_signed(input logic [DIV_OP_W-1:0] op);
    return op[OP_DIV_W] | op[OP_MOD_W];
  endfunction

endpackage

// File: rtl/div_chan_send.sv
// One AXI-stream operand channel towards the divider IP: tvalid is held until
// the handshake, then a sticky flag keeps the channel quiet for the rest of the op.
module div_chan_send (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  input  logic tready,
  output logic tvalid,
  output logic sent,
  output logic fire
);

  logic sent_q;

  assign tvalid = active & ~sent_q;
  assign fire   = tvalid & tready;
  assign sent   = sent_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_q <= 1'b0;
    end else if (clear) begin
      sent_q <= 1'b0;
    end else if (fire) begin
      sent_q <= 1'b1;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Divide controller: pushes one divide op through the signed or unsigned
// divider IP and holds the selected quotient/remainder for the MEM stage.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DIV_OP_W-1:0] div_op,
  input  logic [DW-1:0]     src1,
  input  logic [DW-1:0]     src2,
  input  logic              flush,

  output logic              sdvd_tvalid,
  input  logic              sdvd_tready,
  output logic [DW-1:0]     sdvd_tdata,
  output logic              sdvr_tvalid,
  input  logic              sdvr_tready,
  output logic [DW-1:0]     sdvr_tdata,

  output logic              udvd_tvalid,
  input  logic              udvd_tready,
  output logic [DW-1:0]     udvd_tdata,
  output logic              udvr_tvalid,
  input  logic              udvr_tready,
  output logic [DW-1:0]     udvr_tdata,

  input  logic              sdout_tvalid,
  input  logic [2*DW-1:0]   sdout_tdata,
  input  logic              udout_tvalid,
  input  logic [2*DW-1:0]   udout_tdata,

  output logic              res_valid,
  input  logic              res_ready,
  output logic [DW-1:0]     res_data,
  output logic              busy
);

  div_state_e          state;
  div_state_e          state_nxt;

  logic [DIV_OP_W-1:0] op_q;
  logic [DW-1:0]       src1_q;
  logic [DW-1:0]       src2_q;
  logic [DW-1:0]       res_data_q;
  logic                flushed_q;

  logic                accept;
  logic                capture;
  logic                in_send;
  logic                use_signed;
  logic                is_div;
  logic                is_mod;

  logic                dvd_tvalid;
  logic                dvd_tready;
  logic                dvd_sent;
  logic                dvd_fire;
  logic                dvr_tvalid;
  logic                dvr_tready;
  logic                dvr_sent;
  logic                dvr_fire;
  logic                dvd_done;
  logic                dvr_done;

  logic                dout_valid;
  logic [2*DW-1:0]     dout_data;
  logic [DW-1:0]       dout_sel;

  assign use_signed = op_is_signed(op_q);
  assign is_div     = op_q[OP_DIV_W] | op_q[OP_DIV_WU];
  assign is_mod     = op_q[OP_MOD_W] | op_q[OP_MOD_WU];

  assign in_send    = (state == ST_SEND);
  assign req_ready  = (state == ST_IDLE) & ~flush;
  assign accept     = req_valid & req_ready;

  assign dvd_tready = use_signed ? sdvd_tready : udvd_tready;
  assign dvr_tready = use_signed ? sdvr_tready : udvr_tready;

  div_chan_send u_dvd (
    .clk    (clk),
    .rst_n  (resetn),
    .clear  (accept),
    .active (in_send),
    .tready (dvd_tready),
    .tvalid (dvd_tvalid),
    .sent   (dvd_sent),
    .fire   (dvd_fire)
  );

  div_chan_send u_dvr (
    .clk    (clk),
    .rst_n  (resetn),
    .clear  (accept),
    .active (in_send),
    .tready (dvr_tready),
    .tvalid (dvr_tvalid),
    .sent   (dvr_sent),
    .fire   (dvr_fire)
  );

  // A handshake in the current cycle counts as sent, so WAIT/DRAIN is reached
  // in the same cycle as the last channel completes.
  assign dvd_done = dvd_sent | dvd_fire;
  assign dvr_done = dvr_sent | dvr_fire;

  assign sdvd_tvalid = dvd_tvalid & use_signed;
  assign sdvr_tvalid = dvr_tvalid & use_signed;
  assign udvd_tvalid = dvd_tvalid & ~use_signed;
  assign udvr_tvalid = dvr_tvalid & ~use_signed;

  assign sdvd_tdata  = src1_q;
  assign sdvr_tdata  = src2_q;
  assign udvd_tdata  = src1_q;
  assign udvr_tdata  = src2_q;

  assign dout_valid = use_signed ? sdout_tvalid : udout_tvalid;
  assign dout_data  = use_signed ? sdout_tdata  : udout_tdata;
  assign dout_sel   = is_div ? dout_data[2*DW-1:DW] :
                      (is_mod ? dout_data[DW-1:0] : '0);

  assign res_valid  = (state == ST_DONE);
  assign res_data   = res_data_q;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A flush never abandons a partly sent op: the IP would pair the orphan
  // operand with the next op's, so SEND finishes and the result is drained.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (dvd_done && dvr_done) begin
          state_nxt = (flush || flushed_q) ? ST_DRAIN : ST_WAIT;
        end else if (flush && !dvd_done && !dvr_done) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dout_valid) begin
          if (flush) begin
            state_nxt = ST_IDLE;
          end else begin
            capture   = 1'b1;
            state_nxt = ST_DONE;
          end
        end else if (flush) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (flush || res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (dout_valid) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= '0;
      src1_q <= '0;
      src2_q <= '0;
    end else if (accept) begin
      op_q   <= div_op;
      src1_q <= src1;
      src2_q <= src2;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flushed_q <= 1'b0;
    end else if (accept) begin
      flushed_q <= 1'b0;
    end else if (in_send && flush) begin
      flushed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_data_q <= '0;
    end else if (capture) begin
      res_data_q <= dout_sel;
    end
  end

endmodule
